// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: opcodes, FSM state encoding and
// the leading/trailing-zero count helpers.
package alu_pkg;

  localparam logic [4:0] OP_AND  = 5'd0;
  localparam logic [4:0] OP_OR   = 5'd1;
  localparam logic [4:0] OP_XOR  = 5'd2;
  localparam logic [4:0] OP_NOT  = 5'd3;
  localparam logic [4:0] OP_NOR  = 5'd4;
  localparam logic [4:0] OP_NAND = 5'd5;
  localparam logic [4:0] OP_ADD  = 5'd6;
  localparam logic [4:0] OP_SUB  = 5'd7;
  localparam logic [4:0] OP_MUL  = 5'd8;
  localparam logic [4:0] OP_MULH = 5'd9;
  localparam logic [4:0] OP_DIV  = 5'd10;
  localparam logic [4:0] OP_REM  = 5'd11;
  localparam logic [4:0] OP_CLZ  = 5'd12;
  localparam logic [4:0] OP_CTZ  = 5'd13;
  localparam logic [4:0] OP_ABS  = 5'd14;
  localparam logic [4:0] OP_SLT  = 5'd15;
  localparam logic [4:0] OP_SLL  = 5'd16;
  localparam logic [4:0] OP_SRL  = 5'd17;
  localparam logic [4:0] OP_SRA  = 5'd18;
  localparam logic [4:0] OP_ROL  = 5'd19;
  localparam logic [4:0] OP_ROR  = 5'd20;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StIter,
    StDone
  } alu_state_e;

  // Widest operand the count helpers accept; callers zero-extend into this.
  localparam int MAX_W = 128;

  // Leading zeros within the low w bits of v; returns w for v==0.
  function automatic int clz(input logic [MAX_W-1:0] v, input int w);
    int   cnt;
    logic found;
    cnt   = w;
    found = 1'b0;
    for (int i = MAX_W - 1; i >= 0; i--) begin
      if ((i < w) && v[i] && !found) begin
        cnt   = w - 1 - i;
        found = 1'b1;
      end
    end
    return cnt;
  endfunction

  // Trailing zeros within the low w bits of v; returns w for v==0.
  function automatic int ctz(input logic [MAX_W-1:0] v, input int w);
    int   cnt;
    logic found;
    cnt   = w;
    found = 1'b0;
    for (int i = 0; i < MAX_W; i++) begin
      if ((i < w) && v[i] && !found) begin
        cnt   = i;
        found = 1'b1;
      end
    end
    return cnt;
  endfunction

endpackage

// File: rtl/alu_iter_if.sv
// Request/response bundle between an ALU client (master) and alu_iter (slave).
interface alu_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [4:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             rs1_signed;
  logic             rs2_signed;
  logic             busy;
  logic             valid;
  logic             error;
  logic [WIDTH-1:0] result;
  logic             flag_zero;
  logic             flag_carry;
  logic             flag_ovf;

  modport master (
    output start, op, A, B, rs1_signed, rs2_signed,
    input  busy, valid, error, result, flag_zero, flag_carry, flag_ovf
  );

  modport slave (
    input  start, op, A, B, rs1_signed, rs2_signed,
    output busy, valid, error, result, flag_zero, flag_carry, flag_ovf
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Unsigned shift-add multiplier and restoring divider, one bit per cycle.
// Both share one WIDTH+1 adder and the same hi/lo register pair. Outputs are
// the post-step values, so they are final in the cycle o_done is high.
module alu_muldiv_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_a_mag,
  input  logic [WIDTH-1:0] i_b_mag,
  output logic             o_done,
  output logic [WIDTH-1:0] o_prod_hi,
  output logic [WIDTH-1:0] o_prod_lo,
  output logic [WIDTH-1:0] o_quot,
  output logic [WIDTH-1:0] o_rem
);

  // hi: partial product / partial remainder; lo: multiplier / dividend->quotient
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opnd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_run;
  logic             r_is_div;

  logic [WIDTH:0]   w_x;
  logic [WIDTH:0]   w_y;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic             w_fits;
  logic [WIDTH-1:0] w_hi_d;
  logic [WIDTH-1:0] w_lo_d;

  // Operand select for the shared adder: add multiplicand, or subtract divisor.
  always_comb begin
    if (r_is_div) begin
      w_x   = {r_hi, r_lo[WIDTH-1]};
      w_y   = ~{1'b0, r_opnd};
      w_cin = 1'b1;
    end else begin
      w_x   = {1'b0, r_hi};
      w_y   = r_lo[0] ? {1'b0, r_opnd} : '0;
      w_cin = 1'b0;
    end
  end

  assign w_sum  = w_x + w_y + {{WIDTH{1'b0}}, w_cin};
  // Partial remainder is always < 2*divisor, so bit WIDTH is the borrow.
  assign w_fits = ~w_sum[WIDTH];

  // Next-state of the register pair for one iteration step.
  always_comb begin
    if (r_is_div) begin
      w_hi_d = w_fits ? w_sum[WIDTH-1:0] : w_x[WIDTH-1:0];
      w_lo_d = {r_lo[WIDTH-2:0], w_fits};
    end else begin
      w_hi_d = w_sum[WIDTH:1];
      w_lo_d = {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  assign o_done    = r_run && (r_cnt == CNT_W'(WIDTH - 1));
  assign o_prod_hi = w_hi_d;
  assign o_prod_lo = w_lo_d;
  assign o_quot    = w_lo_d;
  assign o_rem     = w_hi_d;

  // Load operands, then step once per cycle until WIDTH bits are processed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_opnd   <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
      r_is_div <= 1'b0;
    end else if (i_load) begin
      r_hi     <= '0;
      r_lo     <= i_is_div ? i_a_mag : i_b_mag;
      r_opnd   <= i_is_div ? i_b_mag : i_a_mag;
      r_cnt    <= '0;
      r_run    <= 1'b1;
      r_is_div <= i_is_div;
    end else if (r_run) begin
      r_hi  <= w_hi_d;
      r_lo  <= w_lo_d;
      r_cnt <= r_cnt + CNT_W'(1);
      if (o_done) begin
        r_run <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_iter.sv
// Width-generic ALU with a start/busy/valid handshake. Logic, add/sub, count,
// ABS and SLT complete in one cycle; MUL/MULH/DIV/REM run WIDTH iterations in
// alu_muldiv_iter on operand magnitudes, with signs restored here.
// Define ALU_SHIFT_EN to add SLL/SRL/SRA/ROL/ROR on opcodes 16-20.
module alu_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,  // >= 8 and even
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input logic       clk,
  input logic       rst,
  alu_iter_if.slave bus
);

  alu_state_e       r_state;
  logic [4:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_s1;
  logic             r_s2;
  logic             r_busy;
  logic             r_valid;
  logic             r_error;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_carry;
  logic             r_ovf;

  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_is_iter;
  logic               w_is_div;
  logic               w_div0;
  logic               w_load;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_sub;
  logic [CNT_W-1:0]   w_clz;
  logic [CNT_W-1:0]   w_ctz;
  logic [WIDTH-1:0]   w_res;
  logic               w_carry;
  logic               w_ovf;
  logic               w_err;
  logic               w_done;
  logic [WIDTH-1:0]   w_prod_hi;
  logic [WIDTH-1:0]   w_prod_lo;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [2*WIDTH-1:0] w_prod_sgn;
  logic [WIDTH-1:0]   w_quot_sgn;
  logic [WIDTH-1:0]   w_rem_sgn;
  logic [WIDTH-1:0]   w_iter_res;

  assign w_a_neg   = r_s1 & r_a[WIDTH-1];
  assign w_b_neg   = r_s2 & r_b[WIDTH-1];
  // MIN negates to itself, which is the correct unsigned magnitude.
  assign w_a_mag   = w_a_neg ? -r_a : r_a;
  assign w_b_mag   = w_b_neg ? -r_b : r_b;
  assign w_is_iter = (r_op == OP_MUL) || (r_op == OP_MULH) || (r_op == OP_DIV) ||
                     (r_op == OP_REM);
  assign w_is_div  = (r_op == OP_DIV) || (r_op == OP_REM);
  assign w_div0    = (r_b == '0);
  assign w_load    = (r_state == StExec) && w_is_iter && !(w_is_div && w_div0);

  assign w_add = {1'b0, r_a} + {1'b0, r_b};
  assign w_sub = {1'b0, r_a} + {1'b0, ~r_b} + {{WIDTH{1'b0}}, 1'b1};
  assign w_clz = CNT_W'(clz(MAX_W'(r_a), int'(WIDTH)));
  assign w_ctz = CNT_W'(ctz(MAX_W'(r_a), int'(WIDTH)));

`ifdef ALU_SHIFT_EN
  localparam int unsigned SH_W = $clog2(WIDTH);
  logic [SH_W-1:0] w_shamt;
  assign w_shamt = r_b[SH_W-1:0];
`endif

  // Single-cycle results, including the divide-by-zero and illegal-op paths.
  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_err   = 1'b0;
    case (r_op)
      OP_AND:  w_res = r_a & r_b;
      OP_OR:   w_res = r_a | r_b;
      OP_XOR:  w_res = r_a ^ r_b;
      OP_NOT:  w_res = ~r_a;
      OP_NOR:  w_res = ~(r_a | r_b);
      OP_NAND: w_res = ~(r_a & r_b);
      OP_ADD: begin
        w_res   = w_add[WIDTH-1:0];
        w_carry = w_add[WIDTH];
        w_ovf   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_add[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res   = w_sub[WIDTH-1:0];
        w_carry = w_sub[WIDTH];
        w_ovf   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_sub[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_DIV: begin
        w_res = '1;
        w_err = 1'b1;
      end
      OP_REM: begin
        w_res = r_a;
        w_err = 1'b1;
      end
      OP_CLZ:  w_res = {{(WIDTH - CNT_W){1'b0}}, w_clz};
      OP_CTZ:  w_res = {{(WIDTH - CNT_W){1'b0}}, w_ctz};
      OP_ABS: begin
        w_res = r_a[WIDTH-1] ? -r_a : r_a;
        w_ovf = (r_a == {1'b1, {(WIDTH - 1){1'b0}}});
      end
      OP_SLT:  w_res = {{(WIDTH - 1){1'b0}}, ($signed(r_a) < $signed(r_b))};
`ifdef ALU_SHIFT_EN
      OP_SLL:  w_res = r_a << w_shamt;
      OP_SRL:  w_res = r_a >> w_shamt;
      OP_SRA:  w_res = $signed(r_a) >>> w_shamt;
      OP_ROL:  w_res = (r_a << w_shamt) | (r_a >> (WIDTH - 32'(w_shamt)));
      OP_ROR:  w_res = (r_a >> w_shamt) | (r_a << (WIDTH - 32'(w_shamt)));
`endif
      default: w_err = 1'b1;
    endcase
  end

  alu_muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_is_div  (w_is_div),
    .i_a_mag   (w_a_mag),
    .i_b_mag   (w_b_mag),
    .o_done    (w_done),
    .o_prod_hi (w_prod_hi),
    .o_prod_lo (w_prod_lo),
    .o_quot    (w_quot),
    .o_rem     (w_rem)
  );

  // Sign restoration: quotient truncates toward zero, remainder follows dividend.
  assign w_prod_sgn = (w_a_neg ^ w_b_neg) ? -{w_prod_hi, w_prod_lo} : {w_prod_hi, w_prod_lo};
  assign w_quot_sgn = (w_a_neg ^ w_b_neg) ? -w_quot : w_quot;
  assign w_rem_sgn  = w_a_neg ? -w_rem : w_rem;

  // Pick the iterative result matching the latched opcode.
  always_comb begin
    case (r_op)
      OP_MUL:  w_iter_res = w_prod_sgn[WIDTH-1:0];
      OP_MULH: w_iter_res = w_prod_sgn[2*WIDTH-1:WIDTH];
      OP_DIV:  w_iter_res = w_quot_sgn;
      default: w_iter_res = w_rem_sgn;
    endcase
  end

  // Handshake FSM with registered result, flags and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_error  <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_op    <= bus.op;
            r_a     <= bus.A;
            r_b     <= bus.B;
            r_s1    <= bus.rs1_signed;
            r_s2    <= bus.rs2_signed;
            r_busy  <= 1'b1;
            r_state <= StExec;
          end
        end
        StExec: begin
          if (w_load) begin
            r_state <= StIter;
          end else begin
            r_result <= w_res;
            r_zero   <= (w_res == '0);
            r_carry  <= w_carry;
            r_ovf    <= w_ovf;
            r_error  <= w_err;
            r_valid  <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= StIdle;
          end
        end
        StIter: begin
          if (w_done) begin
            r_result <= w_iter_res;
            r_zero   <= (w_iter_res == '0);
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_valid  <= 1'b1;
            r_state  <= StDone;
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.valid      = r_valid;
  assign bus.error      = r_error;
  assign bus.result     = r_result;
  assign bus.flag_zero  = r_zero;
  assign bus.flag_carry = r_carry;
  assign bus.flag_ovf   = r_ovf;

endmodule
